// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
//   Shared types and helpers for the seven-segment refresh scheduler.
//   - scan_state_t : slot phase, BLANK (all digits dark) or ON (digit lit)
//   - DIGIT_W      : bits per displayed digit (one hex nibble)
//   - sel_w(n)     : width of an index that addresses n digits
// ---------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam int unsigned DIGIT_W = 4;

    // Index width for n items; never returns 0 so ports stay legal.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_controller_slot_timer.sv
// ---------------------------------------------------------------------------
// scan_slot_timer
//   Slot counter and BLANK/ON phase machine for one digit slot, plus the
//   PWM counter used to dim the lit phase.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   enable     in   0 holds the timer at cycle 0 of a slot, phase BLANK
//   slot_first out  slot_cnt is 0 (first cycle of the current slot)
//   slot_wrap  out  slot_cnt is SLOT_CYCLES-1 (last cycle of the slot)
//   in_blank   out  current cycle is in the blanking gap
//   pwm_cnt    out  PWM phase counter, 0 on the first ON cycle of a slot
//
// BLANK_CYCLES must be at least 1 and less than SLOT_CYCLES.
// ---------------------------------------------------------------------------
module scan_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 600,
    parameter int unsigned BRIGHT_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic                slot_first,
    output logic                slot_wrap,
    output logic                in_blank,
    output logic [BRIGHT_W-1:0] pwm_cnt
);

    localparam int unsigned CNT_W = sel_w(SLOT_CYCLES);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt;
    scan_state_t      state;

    // Counter and phase share one process so the phase always lines up with
    // the count: BLANK spans counts 0..BLANK_CYCLES-1, ON the remainder.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            slot_cnt <= '0;
            state    <= BLANK;
            pwm_cnt  <= '0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            unique case (state)
                BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state   <= ON;
                        pwm_cnt <= '0;
                    end
                end
                ON: begin
                    if (slot_cnt == SLOT_LAST) begin
                        state <= BLANK;
                    end
                    // Deliberately modulo: the PWM period is 2**BRIGHT_W cycles.
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            endcase
        end
    end

    assign slot_first = (slot_cnt == '0);
    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign in_blank   = (state == BLANK);

endmodule

// File: rtl/seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seg_scan_controller
//   Refresh scheduler for a multiplexed seven-segment display. Time-slices
//   NUM_DIGITS digits with a blanking gap at the start of every slot, dims the
//   lit phase with PWM, and double-buffers the digit data so a new value only
//   takes effect on a frame boundary.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   enable      in   0 = display dark, scan held at slot 0
//   digits_in   in   digit k = digits_in[4k+3:4k]
//   load        in   1-cycle request to capture digits_in
//   load_ack    out  1-cycle pulse when captured data becomes active
//   brightness  in   0 = dark, all ones = full on
//   digit_sel   out  index of the current slot's digit
//   nibble      out  active value of digit digit_sel
//   an_n        out  active-low digit enables (one-hot-low or all ones)
//   frame_start out  high for cycle 0 of slot 0
//
// Every output is a register loaded with the values for the cycle whose
// inputs are sampled on that edge, so digit_sel, nibble and an_n move together.
// ---------------------------------------------------------------------------
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 600,
    parameter int unsigned BRIGHT_W     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]    digits_in,
    input  logic                             load,
    output logic                             load_ack,
    input  logic [BRIGHT_W-1:0]              brightness,
    output logic [sel_w(NUM_DIGITS)-1:0]     digit_sel,
    output logic [DIGIT_W-1:0]               nibble,
    output logic [NUM_DIGITS-1:0]            an_n,
    output logic                             frame_start
);

    localparam int unsigned SEL_W  = sel_w(NUM_DIGITS);
    localparam int unsigned DATA_W = DIGIT_W * NUM_DIGITS;

    localparam logic [SEL_W-1:0] DIGIT_LAST = SEL_W'(NUM_DIGITS - 1);

    // Slot timing
    logic                slot_first;
    logic                slot_wrap;
    logic                in_blank;
    logic [BRIGHT_W-1:0] pwm_cnt;

    // Scan and buffer state
    logic [SEL_W-1:0]  digit_idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;
    logic              pending;

    // Next-cycle values
    logic                 boundary;
    logic                 commit;
    logic [DATA_W-1:0]    active_next;
    logic [SEL_W-1:0]     sel_now;
    logic [DIGIT_W-1:0]   active_digits [NUM_DIGITS];
    logic [DIGIT_W-1:0]   nibble_next;
    logic                 lit;
    logic [NUM_DIGITS-1:0] an_next;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .slot_first (slot_first),
        .slot_wrap  (slot_wrap),
        .in_blank   (in_blank),
        .pwm_cnt    (pwm_cnt)
    );

    always_comb begin
        boundary = enable && slot_first && (digit_idx == '0);
        // Transfer uses the shadow as it stood before this cycle's load.
        commit      = boundary && pending;
        active_next = commit ? shadow : active;

        // digit_idx may still be non-zero on the first disabled cycle.
        sel_now = enable ? digit_idx : '0;

        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            active_digits[k] = active_next[k*DIGIT_W +: DIGIT_W];
        end
        nibble_next = active_digits[sel_now];

        // All-ones must be fully on; pwm_cnt < brightness alone tops out one short.
        lit = (brightness == '1) || (pwm_cnt < brightness);

        an_next = '1;
        if (enable && !in_blank && lit) begin
            an_next[sel_now] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx   <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            digit_sel   <= '0;
            nibble      <= '0;
            an_n        <= '1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (!enable) begin
                digit_idx <= '0;
            end else if (slot_wrap) begin
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
            end

            // A load is never dropped; one landing on a commit stays pending.
            if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            active      <= active_next;
            digit_sel   <= sel_now;
            nibble      <= nibble_next;
            an_n        <= an_next;
            load_ack    <= commit;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_controller
//   Directed scoreboard bench. Stimulus pushes hand-computed expectations
//   tagged with (epoch, cycle, field); the monitor pops and compares them as
//   the DUT presents each cycle's registered outputs. Cycle -1 denotes an
//   edge with reset asserted; cycle 0 is the first edge with reset low.
// ---------------------------------------------------------------------------
module tb_seg_scan_controller;

    localparam int unsigned ND = 2;
    localparam int unsigned SC = 20;
    localparam int unsigned BC = 4;
    localparam int unsigned BW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [7:0]    digits_in = 8'h00;
    logic          load = 1'b0;
    logic [BW-1:0] brightness = 2'd3;
    logic          load_ack;
    logic [0:0]    digit_sel;
    logic [3:0]    nibble;
    logic [ND-1:0] an_n;
    logic          frame_start;

    seg_scan_controller #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits_in   (digits_in),
        .load        (load),
        .load_ack    (load_ack),
        .brightness  (brightness),
        .digit_sel   (digit_sel),
        .nibble      (nibble),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef enum int {F_AN, F_SEL, F_NIB, F_ACK, F_FS} field_t;
    typedef struct {
        int         epoch;
        int         cyc;
        field_t     f;
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   epoch = 0;
    int   ncyc  = 0;

    task automatic push(input string tag, input field_t f, input int c0, input int c1,
                        input logic [7:0] v);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.epoch = epoch;
            e.cyc   = c;
            e.f     = f;
            e.v     = v;
            e.tag   = tag;
            sb.push_back(e);
        end
    endtask

    task automatic push_reset_vals(input string tag);
        push({tag, "_rst_an"},  F_AN,  -1, -1, 8'h03);
        push({tag, "_rst_sel"}, F_SEL, -1, -1, 8'h00);
        push({tag, "_rst_nib"}, F_NIB, -1, -1, 8'h00);
        push({tag, "_rst_ack"}, F_ACK, -1, -1, 8'h00);
        push({tag, "_rst_fs"},  F_FS,  -1, -1, 8'h00);
    endtask

    function automatic logic [7:0] actual(input field_t f);
        case (f)
            F_AN:    return 8'(an_n);
            F_SEL:   return 8'(digit_sel);
            F_NIB:   return 8'(nibble);
            F_ACK:   return 8'(load_ack);
            default: return 8'(frame_start);
        endcase
    endfunction

    // Monitor: each edge presents one cycle's outputs; check everything due.
    always begin : monitor
        logic rs;
        int   cur;
        @(posedge clk);
        rs = reset;
        #1;
        if (rs) begin
            cur  = -1;
            ncyc = 0;
        end else begin
            cur  = ncyc;
            ncyc = ncyc + 1;
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].epoch == epoch && sb[i].cyc == cur) begin
                total++;
                if (actual(sb[i].f) !== sb[i].v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].tag, cur,
                             actual(sb[i].f), sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    // Return at the negedge just before the edge that samples inputs of cycle n.
    task automatic wait_cyc(input int n);
        int guard = 0;
        while (ncyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                total++;
                bad++;
                $display("FAIL wait_cyc got=%0d want=%0d", ncyc, n);
                return;
            end
        end
    endtask

    task automatic do_load(input int c, input logic [7:0] d);
        wait_cyc(c);
        digits_in = d;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic start_test(input logic [BW-1:0] br);
        @(negedge clk);
        epoch++;
        reset      = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        brightness = br;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset release, basic scan
        start_test(2'd3);
        push_reset_vals("t1");
        push("t1_an_blank0", F_AN,  0,  3,  8'h3);
        push("t1_an_lit0",   F_AN,  4,  19, 8'h2);
        push("t1_an_blank1", F_AN,  20, 23, 8'h3);
        push("t1_an_lit1",   F_AN,  24, 39, 8'h1);
        push("t1_fs0",       F_FS,  0,  0,  8'h1);
        push("t1_fs_low",    F_FS,  1,  39, 8'h0);
        push("t1_fs40",      F_FS,  40, 40, 8'h1);
        push("t1_sel0",      F_SEL, 0,  19, 8'h0);
        push("t1_sel1",      F_SEL, 20, 39, 8'h1);
        push("t1_sel_wrap",  F_SEL, 40, 40, 8'h0);
        release_reset();
        wait_cyc(42);

        // 2: load at cycle 7 becomes active at frame boundary 40
        start_test(2'd3);
        push_reset_vals("t2");
        push("t2_nib_old",  F_NIB, 0,  39, 8'h0);
        push("t2_ack_none", F_ACK, 0,  39, 8'h0);
        push("t2_ack40",    F_ACK, 40, 40, 8'h1);
        push("t2_ack_after",F_ACK, 41, 79, 8'h0);
        push("t2_nib_d0",   F_NIB, 40, 59, 8'hA);
        push("t2_nib_d1",   F_NIB, 60, 79, 8'h5);
        release_reset();
        do_load(7, 8'h5A);
        wait_cyc(81);

        // 3a: brightness 0 keeps the display dark
        start_test(2'd0);
        push_reset_vals("t3a");
        push("t3a_dark", F_AN, 0, 39, 8'h3);
        release_reset();
        wait_cyc(41);

        // 3b: brightness 1 lights one cycle in four
        start_test(2'd1);
        push("t3b_blank0", F_AN, 0, 3, 8'h3);
        for (int c = 4; c < 20; c++) begin
            push("t3b_pwm0", F_AN, c, c, (c % 4 == 0) ? 8'h2 : 8'h3);
        end
        push("t3b_blank1", F_AN, 20, 23, 8'h3);
        for (int c = 24; c < 40; c++) begin
            push("t3b_pwm1", F_AN, c, c, (c % 4 == 0) ? 8'h1 : 8'h3);
        end
        release_reset();
        wait_cyc(41);

        // 4: enable drop at 10, load while disabled, re-enable at 16
        start_test(2'd3);
        push("t4_lit",       F_AN,  4,  9,  8'h2);
        push("t4_dark",      F_AN,  11, 19, 8'h3);
        push("t4_sel_dis",   F_SEL, 11, 35, 8'h0);
        push("t4_fs_dis",    F_FS,  11, 15, 8'h0);
        push("t4_fs_re",     F_FS,  16, 16, 8'h1);
        push("t4_fs_after",  F_FS,  17, 17, 8'h0);
        push("t4_ack_none",  F_ACK, 0,  15, 8'h0);
        push("t4_ack16",     F_ACK, 16, 16, 8'h1);
        push("t4_ack_after", F_ACK, 17, 40, 8'h0);
        push("t4_nib_old",   F_NIB, 0,  15, 8'h0);
        push("t4_nib_new",   F_NIB, 16, 35, 8'h7);
        push("t4_lit_re",    F_AN,  20, 35, 8'h2);
        push("t4_blank1",    F_AN,  36, 39, 8'h3);
        push("t4_sel1",      F_SEL, 36, 40, 8'h1);
        push("t4_lit1",      F_AN,  40, 40, 8'h1);
        release_reset();
        wait_cyc(10);
        enable = 1'b0;
        do_load(12, 8'h77);
        wait_cyc(16);
        enable = 1'b1;
        wait_cyc(42);

        // 5: overwrite while pending, then a load on the boundary cycle
        start_test(2'd3);
        push("t5_ack_none", F_ACK, 0,   39,  8'h0);
        push("t5_ack40",    F_ACK, 40,  40,  8'h1);
        push("t5_ack_mid",  F_ACK, 41,  79,  8'h0);
        push("t5_ack80",    F_ACK, 80,  80,  8'h1);
        push("t5_ack_end",  F_ACK, 81,  119, 8'h0);
        push("t5_nib_f1d0", F_NIB, 40,  59,  8'h4);
        push("t5_nib_f1d1", F_NIB, 60,  79,  8'h3);
        push("t5_nib_f2d0", F_NIB, 80,  99,  8'h6);
        push("t5_nib_f2d1", F_NIB, 100, 119, 8'h5);
        release_reset();
        do_load(5, 8'h12);
        do_load(6, 8'h34);
        do_load(40, 8'h56);
        wait_cyc(121);

        // 6: pending load discarded by a mid-frame reset
        start_test(2'd3);
        push("t6_ack_pre", F_ACK, 0, 29, 8'h0);
        push("t6_nib_pre", F_NIB, 0, 29, 8'h0);
        release_reset();
        do_load(5, 8'h9C);
        wait_cyc(30);
        epoch++;
        reset = 1'b1;
        push_reset_vals("t6");
        push("t6_ack_post", F_ACK, 0, 119, 8'h0);
        push("t6_nib_post", F_NIB, 0, 119, 8'h0);
        push("t6_fs_post",  F_FS,  0, 0,   8'h1);
        push("t6_an_post",  F_AN,  4, 19,  8'h2);
        release_reset();
        wait_cyc(121);

        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s never checked got=none want=%h", sb[i].tag, sb[i].v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
